adder_arb_2r: RTL and testbench

- Shares one WIDTH-bit adder datapath between two independent requesters, using round-robin arbitration.
- Each requester presents an operand pair under a valid/ready handshake.
- The winner's sum is registered into a single-entry output buffer, tagged with the requester ID, and held under valid/ready backpressure.
- Sits between client blocks and the shared adder. Throughput is one add per cycle when the output sink does not stall.

---
 rtl/adder_arb_2r.sv | 94 +++++++++
 tb/tb_adder_arb_2r.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arb_2r.sv
// adder_arb_2r: two requesters share one WIDTH-bit adder through a
// round-robin arbiter. The winning sum lands in a single-entry output
// buffer tagged with the requester id, held under valid/ready backpressure.
module adder_arb_2r #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH:0]   o_res_sum,
    output logic             o_res_id,
    output logic             o_busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           last_grant;
    logic           candidate;
    logic           can_accept;
    logic           xfer0;
    logic           xfer1;
    logic [WIDTH:0] sum_next;

    // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last
    always_comb begin
        candidate = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            candidate = ~last_grant;
        end else if (i_req1_valid) begin
            candidate = 1'b1;
        end
    end

    // The buffer can take a new result when empty or when it drains this same cycle
    always_comb begin
        can_accept   = (state == EMPTY) || i_res_ready;
        o_req0_ready = (candidate == 1'b0) && i_req0_valid && can_accept;
        o_req1_ready = (candidate == 1'b1) && i_req1_valid && can_accept;
        xfer0        = i_req0_valid && o_req0_ready;
        xfer1        = i_req1_valid && o_req1_ready;
        sum_next     = xfer1 ? ({1'b0, i_req1_a} + {1'b0, i_req1_b})
                             : ({1'b0, i_req0_a} + {1'b0, i_req0_b});
    end

    // Buffer occupancy: a transfer always fills it, a drain without a transfer empties it
    always_comb begin
        state_next = state;
        if (xfer0 || xfer1) begin
            state_next = FULL;
        end else if ((state == FULL) && i_res_ready) begin
            state_next = EMPTY;
        end
    end

    // Occupancy register; reset discards any buffered result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Result payload and grant pointer only move on a transfer, so stalls keep priority
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_res_sum  <= '0;
            o_res_id   <= 1'b0;
            last_grant <= 1'b1;
        end else if (xfer0 || xfer1) begin
            o_res_sum  <= sum_next;
            o_res_id   <= xfer1;
            last_grant <= xfer1;
        end
    end

    assign o_res_valid = (state == FULL);
    assign o_busy      = (state == FULL) && !i_res_ready;

endmodule

// File: tb/tb_adder_arb_2r.sv
// tb_adder_arb_2r: scoreboard bench for the shared-adder arbiter. A negedge
// monitor predicts readies from its own round-robin model, queues expected
// results on accepted pairs and compares them when the DUT presents them.
module tb_adder_arb_2r;

    localparam int WIDTH = 4;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_req0_valid;
    logic             o_req0_ready;
    logic [WIDTH-1:0] i_req0_a;
    logic [WIDTH-1:0] i_req0_b;
    logic             i_req1_valid;
    logic             o_req1_ready;
    logic [WIDTH-1:0] i_req1_a;
    logic [WIDTH-1:0] i_req1_b;
    logic             o_res_valid;
    logic             i_res_ready;
    logic [WIDTH:0]   o_res_sum;
    logic             o_res_id;
    logic             o_busy;

    int assert_count = 0;
    int fail_count   = 0;

    logic [WIDTH+1:0] exp_q[$];
    logic             model_ptr   = 1'b1;
    logic             model_valid = 1'b0;

    adder_arb_2r #(.WIDTH(WIDTH)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req0_valid (i_req0_valid),
        .o_req0_ready (o_req0_ready),
        .i_req0_a     (i_req0_a),
        .i_req0_b     (i_req0_b),
        .i_req1_valid (i_req1_valid),
        .o_req1_ready (o_req1_ready),
        .i_req1_a     (i_req1_a),
        .i_req1_b     (i_req1_b),
        .o_res_valid  (o_res_valid),
        .i_res_ready  (i_res_ready),
        .o_res_sum    (o_res_sum),
        .o_res_id     (o_res_id),
        .o_busy       (o_busy)
    );

    // Free-running clock, 10 time units per period
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] a0,
                                 input logic [WIDTH-1:0] b0, input logic v1,
                                 input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                 input logic rr);
        i_req0_valid = v0;
        i_req0_a     = a0;
        i_req0_b     = b0;
        i_req1_valid = v1;
        i_req1_a     = a1;
        i_req1_b     = b1;
        i_res_ready  = rr;
    endtask

    task automatic nextCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        i_rst_n = 1'b0;
        nextCycle();
        nextCycle();
        i_rst_n = 1'b1;
    endtask

    // Reference model: predict readies and buffer state, queue expected results
    always @(negedge i_clk) begin
        logic             cand;
        logic             can;
        logic             exp_r0;
        logic             exp_r1;
        logic             next_valid;
        logic [WIDTH+1:0] front;
        if (!i_rst_n) begin
            exp_q.delete();
            model_ptr   = 1'b1;
            model_valid = 1'b0;
        end else begin
            if (i_req0_valid && i_req1_valid) cand = ~model_ptr;
            else                              cand = i_req1_valid;
            can    = !model_valid || i_res_ready;
            exp_r0 = (cand == 1'b0) && i_req0_valid && can;
            exp_r1 = (cand == 1'b1) && i_req1_valid && can;
            checkOutput("req0_ready", 32'(o_req0_ready), 32'(exp_r0));
            checkOutput("req1_ready", 32'(o_req1_ready), 32'(exp_r1));
            checkOutput("res_valid", 32'(o_res_valid), 32'(model_valid));
            checkOutput("busy", 32'(o_busy), 32'(model_valid && !i_res_ready));
            if (model_valid && exp_q.size() > 0) begin
                front = exp_q[0];
                checkOutput("res_sum", 32'(o_res_sum), 32'(front[WIDTH:0]));
                checkOutput("res_id", 32'(o_res_id), 32'(front[WIDTH+1]));
                if (i_res_ready) void'(exp_q.pop_front());
            end
            next_valid = model_valid && !i_res_ready;
            if (exp_r0) begin
                exp_q.push_back({1'b0, ({1'b0, i_req0_a} + {1'b0, i_req0_b})});
                model_ptr  = 1'b0;
                next_valid = 1'b1;
            end
            if (exp_r1) begin
                exp_q.push_back({1'b1, ({1'b0, i_req1_a} + {1'b0, i_req1_b})});
                model_ptr  = 1'b1;
                next_valid = 1'b1;
            end
            model_valid = next_valid;
        end
    end

    // Directed sequence following the test plan; the monitor checks every cycle
    initial begin
        i_rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        #2;
        checkOutput("reset_valid", 32'(o_res_valid), 32'd0);
        checkOutput("reset_sum", 32'(o_res_sum), 32'd0);
        checkOutput("reset_id", 32'(o_res_id), 32'd0);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        doReset();

        // Single request from req0
        applyStimulus(1'b1, 4'h3, 4'h5, 1'b0, '0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("t1_ready0", 32'(o_req0_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("t1_valid", 32'(o_res_valid), 32'd1);
        checkOutput("t1_sum", 32'(o_res_sum), 32'h08);
        checkOutput("t1_id", 32'(o_res_id), 32'd0);
        nextCycle();
        @(negedge i_clk);
        checkOutput("t1_drained", 32'(o_res_valid), 32'd0);
        nextCycle();

        // Continuous dual requests alternate grants
        doReset();
        applyStimulus(1'b1, 4'h1, 4'h1, 1'b1, 4'hF, 4'hF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            checkOutput("t2_grant0", 32'(o_req0_ready), 32'((i % 2) == 0));
            if (i > 0) checkOutput("t2_sum", 32'(o_res_sum), ((i % 2) == 1) ? 32'h02 : 32'h1E);
            nextCycle();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        nextCycle();

        // Stall with a req1 result held in the buffer
        applyStimulus(1'b0, '0, '0, 1'b1, 4'h9, 4'h8, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 4'h2, 4'h4, 1'b1, 4'h7, 4'h7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            checkOutput("t3_stall_r0", 32'(o_req0_ready), 32'd0);
            checkOutput("t3_stall_r1", 32'(o_req1_ready), 32'd0);
            checkOutput("t3_stall_sum", 32'(o_res_sum), 32'h11);
            checkOutput("t3_stall_id", 32'(o_res_id), 32'd1);
            checkOutput("t3_stall_busy", 32'(o_busy), 32'd1);
            nextCycle();
        end
        i_res_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("t3_release_r0", 32'(o_req0_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("t3_after_sum", 32'(o_res_sum), 32'h06);
        checkOutput("t3_after_id", 32'(o_res_id), 32'd0);
        nextCycle();

        // Pointer holds across idle cycles
        applyStimulus(1'b0, '0, '0, 1'b1, 4'h1, 4'h2, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        repeat (5) nextCycle();
        applyStimulus(1'b1, 4'h4, 4'h4, 1'b1, 4'h5, 4'h5, 1'b1);
        @(negedge i_clk);
        checkOutput("t4_first_r0", 32'(o_req0_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        nextCycle();

        // Asynchronous reset while full and stalled
        applyStimulus(1'b0, '0, '0, 1'b1, 4'h2, 4'h2, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 4'h3, 4'h3, 1'b0, '0, '0, 1'b0);
        nextCycle();
        i_rst_n = 1'b0;
        #1;
        checkOutput("t5_async_valid", 32'(o_res_valid), 32'd0);
        checkOutput("t5_async_busy", 32'(o_busy), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        nextCycle();
        i_rst_n = 1'b1;
        applyStimulus(1'b1, 4'h1, 4'h2, 1'b1, 4'h3, 4'h4, 1'b1);
        @(negedge i_clk);
        checkOutput("t5_post_r0", 32'(o_req0_ready), 32'd1);
        nextCycle();

        // Boundary operands, one result per cycle
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, '0, '0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 4'hF, 4'h1, 1'b1);
        @(negedge i_clk);
        checkOutput("t6_zero_sum", 32'(o_res_sum), 32'h00);
        checkOutput("t6_zero_id", 32'(o_res_id), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 4'hF, 4'hF, 1'b0, '0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("t6_carry_sum", 32'(o_res_sum), 32'h10);
        checkOutput("t6_carry_id", 32'(o_res_id), 32'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("t6_max_sum", 32'(o_res_sum), 32'h1E);
        checkOutput("t6_max_id", 32'(o_res_id), 32'd0);
        nextCycle();
        repeat (3) nextCycle();

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
